// File: rtl/arcade_input_cond.sv
// Input conditioning for the 8080 game core: per-channel sync + debounce + rise
// pulse, and a coin stretcher that queues presses and spaces the coin pulses.
module arcade_input_cond #(
   parameter int N         = 8,
   parameter int COIN_IDX  = 2,
   parameter int DB_CYCLES = 1024,
   parameter int COIN_ON   = 65536,
   parameter int COIN_OFF  = 65536,
   parameter int PEND_MAX  = 7
) (
   input  logic         clk_i,
   input  logic         res_i,
   input  logic [N-1:0] raw_i,
   output logic [N-1:0] level_o,
   output logic [N-1:0] rise_o,
   output logic         coin_o,
   output logic [2:0]   pend_o,
   output logic         busy_o
);

   localparam int DB_W    = $clog2(DB_CYCLES + 1);
   localparam int TMR_MAX = (COIN_ON > COIN_OFF) ? COIN_ON : COIN_OFF;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(COIN_ON - 1);
   localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(COIN_OFF - 1);
   localparam logic [2:0]       PEND_SAT = 3'(PEND_MAX);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;

   logic [N-1:0]     s1_q, s1_d;
   logic [N-1:0]     s2_q, s2_d;
   logic [N-1:0]     level_q, level_d;
   logic [N-1:0]     prev_q, prev_d;
   logic [N-1:0]     rise_q, rise_d;
   logic [DB_W-1:0]  db_cnt_q [N];
   logic [DB_W-1:0]  db_cnt_d [N];
   logic [2:0]       pend_q, pend_d;
   logic [1:0]       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             coin_q, coin_d;
   logic             busy_q, busy_d;
   logic             issue;
   logic             coin_rise;

   // A level change is accepted only after DB_CYCLES consecutive disagreeing samples.
   always_comb begin
      s1_d   = raw_i;
      s2_d   = s1_q;
      prev_d = level_q;
      rise_d = level_q & ~prev_q;
      for (int i = 0; i < N; i++) begin
         level_d[i]  = level_q[i];
         db_cnt_d[i] = '0;
         if (s2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               level_d[i] = ~level_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_q != 3'd0) begin
               state_d = ST_ACTIVE;
               tmr_d   = ON_LOAD;
               issue   = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (tmr_q == '0) begin
               state_d = ST_GAP;
               tmr_d   = OFF_LOAD;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_GAP: begin
            if (tmr_q == '0) begin
               if (pend_q != 3'd0) begin
                  state_d = ST_ACTIVE;
                  tmr_d   = ON_LOAD;
                  issue   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
         end
      endcase

      // A rise coinciding with an issue cancels out, even at saturation.
      coin_rise = rise_q[COIN_IDX];
      pend_d    = pend_q;
      if (coin_rise && !issue) begin
         if (pend_q < PEND_SAT) begin
            pend_d = pend_q + 3'd1;
         end
      end else if (issue && !coin_rise) begin
         pend_d = pend_q - 3'd1;
      end

      coin_d = (state_d == ST_ACTIVE);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         s1_q    <= '0;
         s2_q    <= '0;
         level_q <= '0;
         prev_q  <= '0;
         rise_q  <= '0;
         for (int i = 0; i < N; i++) begin
            db_cnt_q[i] <= '0;
         end
         pend_q  <= 3'd0;
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         coin_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         level_q <= level_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
         for (int i = 0; i < N; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
         pend_q  <= pend_d;
         state_q <= state_d;
         tmr_q   <= tmr_d;
         coin_q  <= coin_d;
         busy_q  <= busy_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign coin_o  = coin_q;
   assign pend_o  = pend_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_arcade_input_cond.sv
// Bench for arcade_input_cond: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against a behavioural model.
module tb_arcade_input_cond;

   localparam int N        = 8;
   localparam int COIN_IDX = 2;
   localparam int DB       = 4;
   localparam int ON       = 8;
   localparam int OFF      = 4;
   localparam int PMAX     = 7;

   logic         clk_i = 1'b0;
   logic         res_i = 1'b1;
   logic [N-1:0] raw_i = '0;
   logic [N-1:0] level_o;
   logic [N-1:0] rise_o;
   logic         coin_o;
   logic [2:0]   pend_o;
   logic         busy_o;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   always #5 clk_i = ~clk_i;

   arcade_input_cond #(
      .N(N), .COIN_IDX(COIN_IDX), .DB_CYCLES(DB),
      .COIN_ON(ON), .COIN_OFF(OFF), .PEND_MAX(PMAX)
   ) dut (
      .clk_i(clk_i), .res_i(res_i), .raw_i(raw_i),
      .level_o(level_o), .rise_o(rise_o), .coin_o(coin_o),
      .pend_o(pend_o), .busy_o(busy_o)
   );

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: sync is a two-sample delay, a level flips once the last DB synced
   // samples all disagree with it, coins start whenever something is pending
   // and at least ON+OFF edges have passed since the previous start.
   bit [N-1:0] m_s1, m_s2, m_level, m_prev, m_rise;
   bit [N-1:0] m_hist [DB];
   int m_pend, m_next_ok, m_last_s, m_k;
   bit m_coin, m_busy;

   always @(posedge clk_i) begin
      bit [N-1:0] old_level;
      bit inc, start, all_diff;
      m_k++;
      if (res_i) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_prev = '0; m_rise = '0;
         for (int j = 0; j < DB; j++) m_hist[j] = '0;
         m_pend = 0; m_next_ok = 0; m_last_s = -100000;
         m_coin = 1'b0; m_busy = 1'b0;
      end else begin
         inc   = m_rise[COIN_IDX];
         start = (m_pend > 0) && (m_k >= m_next_ok);
         if (start) begin
            m_last_s  = m_k;
            m_next_ok = m_k + ON + OFF;
         end
         if (inc && !start) m_pend = (m_pend + 1 > PMAX) ? PMAX : m_pend + 1;
         else if (start && !inc) m_pend = m_pend - 1;
         m_coin = (m_k - m_last_s) < ON;
         m_busy = m_k < m_next_ok;

         for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = m_s2;
         old_level = m_level;
         for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) if (m_hist[j][i] == old_level[i]) all_diff = 1'b0;
            if (all_diff) m_level[i] = ~old_level[i];
         end
         m_rise = old_level & ~m_prev;
         m_prev = old_level;
         m_s2 = m_s1;
         m_s1 = raw_i;
      end
   end

   always @(negedge clk_i) begin
      if (cmp_en) begin
         check_output("cyc_level", int'(level_o), int'(m_level));
         check_output("cyc_rise",  int'(rise_o),  int'(m_rise));
         check_output("cyc_coin",  int'(coin_o),  int'(m_coin));
         check_output("cyc_pend",  int'(pend_o),  m_pend);
         check_output("cyc_busy",  int'(busy_o),  int'(m_busy));
      end
   end

   // Pulse statistics gathered from the DUT outputs for the directed scenarios.
   int pulses, hi_run, lo_run, hi_bad, gap_min, gap_max, pend_peak;
   bit had_pulse, prev_coin;
   logic [N-1:0] level_seen, rise_seen;

   always @(negedge clk_i) begin
      level_seen = level_seen | level_o;
      rise_seen  = rise_seen | rise_o;
      if (int'(pend_o) > pend_peak) pend_peak = int'(pend_o);
      if (coin_o === 1'b1) begin
         if (!prev_coin) begin
            pulses++;
            if (had_pulse) begin
               if (lo_run < gap_min) gap_min = lo_run;
               if (lo_run > gap_max) gap_max = lo_run;
            end
            hi_run = 1;
         end else begin
            hi_run++;
         end
         prev_coin = 1'b1;
      end else begin
         if (prev_coin) begin
            if (hi_run != ON) hi_bad++;
            had_pulse = 1'b1;
            lo_run = 1;
         end else begin
            lo_run++;
         end
         prev_coin = 1'b0;
      end
   end

   task automatic clear_stats();
      pulses = 0; hi_bad = 0; gap_min = 1000000; gap_max = 0; pend_peak = 0;
      had_pulse = 1'b0; level_seen = '0; rise_seen = '0;
   endtask

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic press_coin(input int n);
      for (int p = 0; p < n; p++) begin
         raw_i[COIN_IDX] = 1'b1;
         repeat (DB) tick();
         raw_i[COIN_IDX] = 1'b0;
         repeat (DB) tick();
      end
   endtask

   task automatic apply_stimulus();
      bit found;
      clear_stats();
      res_i = 1'b1;
      raw_i = '0;
      repeat (3) tick();
      cmp_en = 1'b1;
      check_output("rst_level", int'(level_o), 0);
      check_output("rst_rise",  int'(rise_o),  0);
      check_output("rst_coin",  int'(coin_o),  0);
      check_output("rst_pend",  int'(pend_o),  0);
      check_output("rst_busy",  int'(busy_o),  0);
      res_i = 1'b0;
      repeat (2) tick();

      // Channel 0 press and release latency.
      raw_i[0] = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (t == 5) check_output("t1_level_e5", int'(level_o[0]), 0);
         if (t == 6) check_output("t1_level_e6", int'(level_o[0]), 1);
         if (t == 6) check_output("t1_rise_e6",  int'(rise_o[0]),  0);
         if (t == 7) check_output("t1_rise_e7",  int'(rise_o[0]),  1);
         if (t == 8) check_output("t1_rise_e8",  int'(rise_o[0]),  0);
      end
      clear_stats();
      raw_i[0] = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (t == 5) check_output("t1_rel_e5", int'(level_o[0]), 1);
         if (t == 6) check_output("t1_rel_e6", int'(level_o[0]), 0);
      end
      check_output("t1_rel_norise", int'(rise_seen[0]), 0);

      // Short glitch on channel 5.
      clear_stats();
      raw_i[5] = 1'b1;
      repeat (3) tick();
      raw_i[5] = 1'b0;
      repeat (12) tick();
      check_output("t2_glitch_level", int'(level_seen[5]), 0);
      check_output("t2_glitch_rise",  int'(rise_seen[5]),  0);

      // Single coin press.
      clear_stats();
      raw_i[COIN_IDX] = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (t == 7)  check_output("t3_rise",    int'(rise_o[COIN_IDX]), 1);
         if (t == 8)  check_output("t3_pend_up", int'(pend_o), 1);
         if (t == 8)  check_output("t3_coin_e8", int'(coin_o), 0);
         if (t == 9)  check_output("t3_coin_e9", int'(coin_o), 1);
         if (t == 9)  check_output("t3_pend_dn", int'(pend_o), 0);
         if (t == 16) check_output("t3_coin_e16", int'(coin_o), 1);
         if (t == 17) check_output("t3_coin_e17", int'(coin_o), 0);
         if (t == 20) check_output("t3_busy_e20", int'(busy_o), 1);
         if (t == 21) check_output("t3_busy_e21", int'(busy_o), 0);
         if (t == 20) raw_i[COIN_IDX] = 1'b0;
      end
      check_output("t3_pulses", pulses, 1);
      check_output("t3_hi_bad", hi_bad, 0);
      check_output("t3_peak",   pend_peak, 1);

      // Four back-to-back presses queue up behind each other.
      clear_stats();
      press_coin(4);
      repeat (60) tick();
      check_output("t4_pulses",  pulses, 4);
      check_output("t4_hi_bad",  hi_bad, 0);
      check_output("t4_gap_min", gap_min, OFF);
      check_output("t4_gap_max", gap_max, OFF);
      check_output("t4_peak",    pend_peak, 2);
      check_output("t4_pend_end", int'(pend_o), 0);
      check_output("t4_busy_end", int'(busy_o), 0);

      // Sustained presses outrun the coin rate and saturate the counter.
      clear_stats();
      press_coin(30);
      check_output("t5_peak",    pend_peak, PMAX);
      check_output("t5_hi_bad",  hi_bad, 0);
      check_output("t5_dropped", int'(pulses < 30), 1);

      // Reset in the third cycle of a pulse with two coins pending.
      found = 1'b0;
      for (int w = 0; w < 600 && !found; w++) begin
         if (coin_o && pend_o == 3'd2 && hi_run == 3) found = 1'b1;
         else tick();
      end
      check_output("t6_found", int'(found), 1);
      res_i = 1'b1;
      tick();
      check_output("t6_coin",  int'(coin_o),  0);
      check_output("t6_pend",  int'(pend_o),  0);
      check_output("t6_busy",  int'(busy_o),  0);
      check_output("t6_level", int'(level_o), 0);
      check_output("t6_rise",  int'(rise_o),  0);
      res_i = 1'b0;
      clear_stats();
      repeat (40) tick();
      check_output("t6_no_pulses", pulses, 0);

      // Random activity on all channels with occasional resets.
      for (int c = 0; c < 900; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 99) < ((c < 450) ? 10 : 25)) raw_i[b] = ~raw_i[b];
         end
         res_i = ($urandom_range(0, 299) == 0);
         tick();
      end
      res_i = 1'b0;
      raw_i = '0;
      repeat (150) tick();
   endtask

   initial begin
      apply_stimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
